hvcc_charge_seq: RTL and testbench
==================================

HVCC_CHARGE_SEQ -- requirements
Module: hvcc_charge_seq

Interface
REQ-001 Parameter FIRE_CYC, default 16: number of cycles `dump` is held high per fire.
REQ-002 Parameter SYNC_STAGES, default 2: number of synchronizer flops on `v_ok`.
REQ-003 Port `clk`, input, 1: the only clock; all state changes on its rising edge.
REQ-004 Port `rst`, input, 1: synchronous, active-high reset.
REQ-005 Port `start`, input, 1: request a charge cycle; sampled in IDLE only.
REQ-006 Port `abort`, input, 1: terminate any activity; also clears FAULT.
REQ-007 Port `fire_req`, input, 1: request discharge; sampled in READY only.
REQ-008 Port `v_ok`, input, 1: asynchronous comparator, high means cap voltage at or above target.
REQ-009 Port `t_on`, input, 8: gate-high cycles per pulse.
REQ-010 Port `t_off`, input, 8: gate-low cycles per pulse.
REQ-011 Port `max_pulses`, input, 16: pulse budget before fault.
REQ-012 Port `gate`, output, 1: charger switch drive; registered.
REQ-013 Port `dump`, output, 1: discharge/fire drive; registered.
REQ-014 Port `ready`, output, 1: high while in READY.
REQ-015 Port `busy`, output, 1: high in ON, OFF or FIRE.
REQ-016 Port `fault`, output, 1: high in FAULT.
REQ-017 Port `state`, output, 3: current state encoding.
REQ-018 Port `pulse_cnt`, output, 16: pulses issued in the current cycle.

Function
REQ-019 State encoding SHALL be IDLE=0, ON=1, OFF=2, READY=3, FIRE=4, FAULT=5; codes 6-7 SHALL go to IDLE on the next edge.
REQ-020 `v_ok` SHALL pass through SYNC_STAGES flops; only the synchronized value `v_ok_s` SHALL be used.
REQ-021 IDLE, on `start`=1 and `abort`=0:
- latch `t_on`, `t_off`, `max_pulses` into internal registers;
- clear `pulse_cnt`;
- go to ON; or go to FAULT if latched `t_on`==0 or `max_pulses`==0.
REQ-022 Input changes to `t_on`, `t_off` and `max_pulses` after latching SHALL have no effect until the next `start` accepted in IDLE.
REQ-023 ON: `gate`=1 for exactly t_on cycles, then go to OFF; `pulse_cnt` increments on the ON->OFF transition.
REQ-024 `gate` SHALL first be high in the cycle after the edge that sampled `start`.
REQ-025 OFF: `gate`=0 for max(t_off,1) cycles; `v_ok_s` is sampled only in the last OFF cycle, then:
- `v_ok_s`=1 -> READY;
- else `pulse_cnt`==latched max -> FAULT;
- else -> ON.
REQ-026 READY:
- `fire_req`=1 -> FIRE;
- else `v_ok_s`=0 (droop) -> ON for a top-up pulse, `pulse_cnt` not cleared, budget still enforced.
REQ-027 If `fire_req` and droop occur in the same READY cycle, `fire_req` SHALL win.
REQ-028 FIRE: `dump`=1 for exactly FIRE_CYC cycles with `gate`=0, then go to IDLE.
REQ-029 FAULT SHALL be sticky and ignore `start` and `fire_req`; `abort`=1 -> IDLE.
REQ-030 `abort`=1 in any state SHALL force IDLE at the next edge and take priority over every other input.
REQ-031 After `abort`, `gate`=0 and `dump`=0 from the cycle after `abort` is sampled; an aborted FIRE SHALL truncate `dump`.
REQ-032 `gate` and `dump` SHALL never be high in the same cycle.
REQ-033 `pulse_cnt` SHALL saturate at 16'hFFFF and never wrap.
REQ-034 `start` outside IDLE and `fire_req` outside READY SHALL be ignored, with no queuing.

Reset
REQ-035 `rst`=1 at an edge SHALL, regardless of `abort` or any other input:
- set state=IDLE;
- clear `gate`, `dump`, `ready`, `busy`, `fault`, `pulse_cnt`, all timers, latched parameters and synchronizer flops.
REQ-036 Reset asserted mid-operation (ON or FIRE) SHALL drop `gate`/`dump` in the cycle after the reset edge.
REQ-037 Outputs SHALL stay at reset values until the first `start` following `rst` deassertion.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
- Normal charge: t_on=4, t_off=12, max=10, `v_ok` rising during pulse 3 -> exactly 3 gate pulses of 4 cycles, then READY, `pulse_cnt`=3.
- Timeout: `v_ok`=0, max=5 -> 5 pulses then FAULT; `start` ignored; `abort` -> IDLE.
- Fire: in READY, `fire_req` -> `dump` high for exactly 16 cycles, then IDLE with `busy`=0.
- Droop top-up: in READY drop `v_ok` -> one extra ON pulse, `pulse_cnt` 3->4, back to READY.
- Abort mid-ON at cycle 2 of 4 -> `gate` low the next cycle, state=IDLE; also `abort` and `start` in the same IDLE cycle -> stays IDLE.
- Edge parameters: t_on=0 -> FAULT on the cycle after `start`; t_off=0 -> 1-cycle OFF; `rst` during FIRE -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/hvcc_charge_seq.sv
// High-voltage capacitor charge sequencer: pulses the charger gate until the
// synchronized comparator reports target voltage, then holds READY until fired.
module hvcc_charge_seq #(
    parameter int unsigned FIRE_CYC    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        fire_req,
    input  logic        v_ok,
    input  logic [7:0]  t_on,
    input  logic [7:0]  t_off,
    input  logic [15:0] max_pulses,
    output logic        gate,
    output logic        dump,
    output logic        ready,
    output logic        busy,
    output logic        fault,
    output logic [2:0]  state,
    output logic [15:0] pulse_cnt
);
    localparam int unsigned TW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned SW = 3;

    localparam logic [SW-1:0] S_IDLE  = 3'd0;
    localparam logic [SW-1:0] S_ON    = 3'd1;
    localparam logic [SW-1:0] S_OFF   = 3'd2;
    localparam logic [SW-1:0] S_READY = 3'd3;
    localparam logic [SW-1:0] S_FIRE  = 3'd4;
    localparam logic [SW-1:0] S_FAULT = 3'd5;

    logic [SW-1:0] state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    t_on_l, t_off_l;
    logic [CW-1:0] max_l;
    logic          latch_en;
    logic          v_ok_s;
    logic [TW-1:0] on_load, off_load;
    logic          gate_d, dump_d, ready_d, busy_d, fault_d;

    // Comparator synchronizer chain
    logic [SYNC_STAGES-1:0] sync_q;
    generate
        if (SYNC_STAGES == 1) begin : g_sync1
            always_ff @(posedge clk) begin
                if (rst) sync_q <= '0;
                else     sync_q <= v_ok;
            end
        end else begin : g_syncn
            always_ff @(posedge clk) begin
                if (rst) sync_q <= '0;
                else     sync_q <= {sync_q[SYNC_STAGES-2:0], v_ok};
            end
        end
    endgenerate
    assign v_ok_s = sync_q[SYNC_STAGES-1];

    // Timer reload values; a zero off-time still spends one cycle in OFF
    assign on_load  = TW'(t_on_l) - TW'(1);
    assign off_load = (t_off_l == 8'd0) ? '0 : (TW'(t_off_l) - TW'(1));

    // State, timer and pulse counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    // Charge parameters captured only when a start is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            t_on_l  <= '0;
            t_off_l <= '0;
            max_l   <= '0;
        end else if (latch_en) begin
            t_on_l  <= t_on;
            t_off_l <= t_off;
            max_l   <= max_pulses;
        end
    end

    // Next-state, timer and counter logic; abort overrides everything
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        latch_en = 1'b1;
                        cnt_d    = '0;
                        if (t_on == 8'd0 || max_pulses == 16'd0) begin
                            state_d = S_FAULT;
                            timer_d = '0;
                        end else begin
                            state_d = S_ON;
                            timer_d = TW'(t_on) - TW'(1);
                        end
                    end
                end
                S_ON: begin
                    if (timer_q == '0) begin
                        state_d = S_OFF;
                        timer_d = off_load;
                        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_OFF: begin
                    if (timer_q == '0) begin
                        if (v_ok_s) begin
                            state_d = S_READY;
                        end else if (cnt_q >= max_l) begin
                            state_d = S_FAULT;
                        end else begin
                            state_d = S_ON;
                            timer_d = on_load;
                        end
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
                S_READY: begin
                    // Fire wins over a droop seen in the same cycle
                    if (fire_req) begin
                        state_d = S_FIRE;
                        timer_d = TW'(FIRE_CYC - 1);
                    end else if (!v_ok_s) begin
                        state_d = S_ON;
                        timer_d = on_load;
                    end
                end
                S_FIRE: begin
                    if (timer_q == '0) state_d = S_IDLE;
                    else               timer_d = timer_q - TW'(1);
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state so the registered outputs track state_q
    always_comb begin
        gate_d  = 1'b0;
        dump_d  = 1'b0;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        fault_d = 1'b0;
        case (state_d)
            S_ON: begin
                gate_d = 1'b1;
                busy_d = 1'b1;
            end
            S_OFF:   busy_d  = 1'b1;
            S_READY: ready_d = 1'b1;
            S_FIRE: begin
                dump_d = 1'b1;
                busy_d = 1'b1;
            end
            S_FAULT: fault_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gate  <= 1'b0;
            dump  <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b0;
            fault <= 1'b0;
        end else begin
            gate  <= gate_d;
            dump  <= dump_d;
            ready <= ready_d;
            busy  <= busy_d;
            fault <= fault_d;
        end
    end

    assign state     = state_q;
    assign pulse_cnt = cnt_q;

endmodule

// File: tb/tb_hvcc_charge_seq.sv
// Directed bench for hvcc_charge_seq: charge, droop top-up, fire, timeout,
// abort, degenerate parameters and reset during fire.
module tb_hvcc_charge_seq;
    logic        clk = 1'b0;
    logic        rst, start, abort, fire_req, v_ok;
    logic [7:0]  t_on, t_off;
    logic [15:0] max_pulses;
    logic        gate, dump, ready, busy, fault;
    logic [2:0]  state;
    logic [15:0] pulse_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int excl_viol = 0;
    int cyc, np, mn, mx, dcnt;

    hvcc_charge_seq #(.FIRE_CYC(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .fire_req(fire_req),
        .v_ok(v_ok), .t_on(t_on), .t_off(t_off), .max_pulses(max_pulses),
        .gate(gate), .dump(dump), .ready(ready), .busy(busy), .fault(fault),
        .state(state), .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (gate && dump) excl_viol++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clock until `target` is reached after at least one gate pulse, measuring pulses.
    // With noise set, start/fire_req/parameters are scrambled after the first edge.
    task automatic charge_until(input logic [2:0] target, input int budget, input int vok_pulse,
                                input bit noise, output int cycles, output int pulses,
                                output int min_run, output int max_run);
        int  run;
        logic prev;
        run = 0; prev = gate; pulses = 0; min_run = 1000; max_run = 0; cycles = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            cycles++;
            if (i == 0) begin
                start = 1'b0;
                if (noise) begin
                    start = 1'b1; fire_req = 1'b1;
                    t_on = 8'd9; t_off = 8'd1; max_pulses = 16'd1;
                end
            end
            if (gate) begin
                run++;
                if (!prev) begin
                    pulses++;
                    if (pulses == vok_pulse) v_ok = 1'b1;
                end
            end else if (prev) begin
                if (run < min_run) min_run = run;
                if (run > max_run) max_run = run;
                run = 0;
            end
            prev = gate;
            if (state == target && pulses > 0) break;
        end
        start = 1'b0;
        fire_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; abort = 1'b1; fire_req = 1'b1; v_ok = 1'b1;
        t_on = 8'd4; t_off = 8'd12; max_pulses = 16'd10;
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_gate", gate, 0);
        check("rst_dump", dump, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        check("rst_cnt", pulse_cnt, 0);
        rst = 1'b0; start = 1'b0; abort = 1'b0; fire_req = 1'b0; v_ok = 1'b0;
        tick(); tick(); tick();
        check("post_rst_state", state, 0);
        check("post_rst_busy", busy, 0);

        // Normal charge: v_ok rises during pulse 3 -> READY after 3 pulses
        start = 1'b1;
        charge_until(3'd3, 200, 3, 1'b1, cyc, np, mn, mx);
        check("chg_cycles", cyc, 49);
        check("chg_pulses", np, 3);
        check("chg_min_run", mn, 4);
        check("chg_max_run", mx, 4);
        check("chg_cnt", pulse_cnt, 3);
        check("chg_ready", ready, 1);
        check("chg_busy", busy, 0);
        check("chg_gate", gate, 0);

        // Droop top-up: one extra pulse with latched timing, back to READY
        v_ok = 1'b0;
        charge_until(3'd3, 100, 1, 1'b0, cyc, np, mn, mx);
        check("droop_cycles", cyc, 19);
        check("droop_pulses", np, 1);
        check("droop_run", mx, 4);
        check("droop_cnt", pulse_cnt, 4);
        check("droop_ready", ready, 1);

        // Fire coinciding with a droop: fire wins, dump lasts 16 cycles
        v_ok = 1'b0;
        tick(); tick();
        check("pre_fire_state", state, 3);
        fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        check("fire_state", state, 4);
        check("fire_gate", gate, 0);
        check("fire_busy", busy, 1);
        dcnt = dump ? 1 : 0;
        cyc = 0;
        while (state != 3'd0 && cyc < 40) begin
            tick();
            cyc++;
            if (dump) dcnt++;
        end
        check("fire_dump_len", dcnt, 16);
        check("fire_to_idle", cyc, 16);
        check("fire_end_busy", busy, 0);
        check("fire_end_dump", dump, 0);

        // Timeout with t_off=0 (1-cycle OFF): 5 pulses of 2 then FAULT
        t_on = 8'd2; t_off = 8'd0; max_pulses = 16'd5;
        start = 1'b1;
        charge_until(3'd5, 100, 0, 1'b1, cyc, np, mn, mx);
        check("to_cycles", cyc, 16);
        check("to_pulses", np, 5);
        check("to_run", mx, 2);
        check("to_fault", fault, 1);
        check("to_cnt", pulse_cnt, 5);
        start = 1'b1; fire_req = 1'b1;
        tick(); tick();
        check("fault_sticky", state, 5);
        check("fault_flag", fault, 1);
        start = 1'b0; fire_req = 1'b0; abort = 1'b1;
        tick();
        check("fault_abort_state", state, 0);
        check("fault_abort_flag", fault, 0);
        start = 1'b1;
        tick();
        check("idle_abort_start", state, 0);
        check("idle_abort_gate", gate, 0);
        start = 1'b0; abort = 1'b0;
        tick();

        // Abort at cycle 2 of a 4-cycle ON
        t_on = 8'd4; t_off = 8'd3; max_pulses = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ab_on_state", state, 1);
        check("ab_on_gate1", gate, 1);
        tick();
        check("ab_on_gate2", gate, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_state", state, 0);
        check("ab_gate", gate, 0);
        check("ab_busy", busy, 0);
        tick();
        check("ab_no_resume", state, 0);

        // Degenerate parameters go straight to FAULT
        t_on = 8'd0; max_pulses = 16'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("ton0_state", state, 5);
        check("ton0_gate", gate, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        t_on = 8'd3; max_pulses = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("max0_state", state, 5);
        abort = 1'b1; tick(); abort = 1'b0;
        check("max0_abort", state, 0);

        // Reset during FIRE clears every output on the next cycle
        v_ok = 1'b1; t_on = 8'd1; t_off = 8'd0; max_pulses = 16'd2;
        tick(); tick();
        start = 1'b1;
        charge_until(3'd3, 20, 0, 1'b0, cyc, np, mn, mx);
        check("rf_cycles", cyc, 3);
        check("rf_ready", ready, 1);
        fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        check("rf_dump", dump, 1);
        tick();
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        check("rf_state", state, 0);
        check("rf_dump0", dump, 0);
        check("rf_gate0", gate, 0);
        check("rf_busy0", busy, 0);
        check("rf_cnt0", pulse_cnt, 0);
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        tick();
        check("rf_idle", state, 0);

        check("gate_dump_excl", excl_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
